cla_pipe_addsub: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake at both ends. It is the next generation of the team's registered N-bit CLA adder. New capabilities: configurable width, lookahead group size and pipeline depth; add/subtract mode; carry-in; carry-out; signed overflow; backpressure. It sits in datapath front-ends that feed accumulators and comparators.

---
 rtl/cla_pkg.sv | 43 ++++
 rtl/cla_group.sv | 31 +++
 rtl/cla_pipe_addsub.sv | 156 +++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the pipelined CLA adder/subtractor.
// When CLA_SAT_EN is defined, the per-stage control payload also carries the saturation flag.
package cla_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

  // Legal shape: N splits evenly into STAGES slices of whole groups; each level of lookahead fits 32 bits.
  function automatic bit cla_cfg_ok(input int unsigned n, input int unsigned group,
                                    input int unsigned stages);
    if (group == 0 || stages == 0 || group > 32) return 1'b0;
    if ((n % (stages * group)) != 0) return 1'b0;
    return (n / (stages * group)) <= 32;
  endfunction

  // Carry into position j of a generate/propagate vector, in flattened lookahead form.
  function automatic logic la_carry(input logic [31:0] gv, input logic [31:0] pv,
                                    input logic c0, input int unsigned j);
    logic acc;
    logic term;
    acc = c0;
    for (int unsigned i = 0; i < j; i++) acc = acc & pv[i];
    for (int unsigned i = 0; i < j; i++) begin
      term = gv[i];
      for (int unsigned m = i + 1; m < j; m++) term = term & pv[m];
      acc = acc | term;
    end
    return acc;
  endfunction

  typedef struct packed {
    logic valid;
    logic carry;
`ifdef CLA_SAT_EN
    logic sat;
`endif
  } cla_ctrl_t;

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead block: sum plus group generate/propagate.
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             g,
  output logic             p
);
  logic [GROUP-1:0] gen;
  logic [GROUP-1:0] prop;
  logic [GROUP-1:0] c;

  assign gen  = a & b;
  assign prop = a ^ b;
  // g/p are kept apart from the ci-dependent logic so the upper lookahead sees no false loop.
  assign g    = la_carry(32'(gen), 32'(prop), 1'b0, GROUP);
  assign p    = &prop;

  always_comb begin
    c = '0;
    for (int unsigned i = 0; i < GROUP; i++) c[i] = la_carry(32'(gen), 32'(prop), ci, i);
  end

  assign s = prop ^ c;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor; stage k resolves bits [k*W +: W], W = N/STAGES.
// Define CLA_SAT_EN to add the sat input (signed saturation on overflow).
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         cin,
`ifdef CLA_SAT_EN
  input  logic         sat,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int unsigned W   = N / STAGES;
  localparam int unsigned GPS = W / GROUP;
  localparam int unsigned NG  = N / GROUP;

  if (!cla_cfg_ok(N, GROUP, STAGES)) begin : g_bad_cfg
    $error("cla_pipe_addsub: N must be a multiple of STAGES*GROUP");
  end

  cla_ctrl_t      ctrl_v [STAGES];
  cla_ctrl_t      ctrl_d [STAGES];
  cla_ctrl_t      ctrl_q [STAGES];
  logic [N-1:0]   a_v    [STAGES];
  logic [N-1:0]   be_v   [STAGES];
  logic [N-1:0]   s_v    [STAGES];
  logic [N-1:0]   a_d    [STAGES];
  logic [N-1:0]   be_d   [STAGES];
  logic [N-1:0]   s_d    [STAGES];
  logic [N-1:0]   a_q    [STAGES];
  logic [N-1:0]   be_q   [STAGES];
  logic [N-1:0]   s_q    [STAGES];
  logic           gg     [NG];
  logic           gp     [NG];
  logic           gc     [NG];
  logic [GROUP-1:0] gs   [NG];
  logic           cs     [STAGES];
  logic [GPS-1:0] gvec;
  logic [GPS-1:0] pvec;
  logic           ovf_d;
  logic           ovf_q;
  logic           advance;

  // Stage inputs: stage 0 sees the ports, later stages see the previous register.
  // B is inverted once at entry, so no later stage needs to know the mode.
  always_comb begin
    ctrl_v[0]       = '0;
    ctrl_v[0].valid = in_valid;
    ctrl_v[0].carry = sub | cin;
`ifdef CLA_SAT_EN
    ctrl_v[0].sat   = sat;
`endif
    a_v[0]  = a;
    be_v[0] = b ^ {N{sub}};
    s_v[0]  = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      ctrl_v[k] = ctrl_q[k-1];
      a_v[k]    = a_q[k-1];
      be_v[k]   = be_q[k-1];
      s_v[k]    = s_q[k-1];
    end
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    localparam int unsigned STG = gi / GPS;
    cla_group #(.GROUP(GROUP)) u_grp (
      .a  (a_v[STG][gi*GROUP +: GROUP]),
      .b  (be_v[STG][gi*GROUP +: GROUP]),
      .ci (gc[gi]),
      .s  (gs[gi]),
      .g  (gg[gi]),
      .p  (gp[gi])
    );
  end

  // Group-level lookahead inside each slice, seeded by that slice's incoming carry.
  always_comb begin
    gvec = '0;
    pvec = '0;
    for (int unsigned i = 0; i < NG; i++) gc[i] = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) cs[k] = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      for (int unsigned j = 0; j < GPS; j++) begin
        gvec[j] = gg[k*GPS + j];
        pvec[j] = gp[k*GPS + j];
      end
      for (int unsigned j = 0; j < GPS; j++)
        gc[k*GPS + j] = la_carry(32'(gvec), 32'(pvec), ctrl_v[k].carry, j);
      cs[k] = la_carry(32'(gvec), 32'(pvec), ctrl_v[k].carry, GPS);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      ctrl_d[k]       = ctrl_v[k];
      ctrl_d[k].carry = cs[k];
      a_d[k]          = a_v[k];
      be_d[k]         = be_v[k];
      s_d[k]          = s_v[k];
      for (int unsigned j = 0; j < GPS; j++)
        s_d[k][(k*GPS + j)*GROUP +: GROUP] = gs[k*GPS + j];
    end
    ovf_d = (a_v[STAGES-1][N-1] == be_v[STAGES-1][N-1]) &&
            (s_d[STAGES-1][N-1] != a_v[STAGES-1][N-1]);
`ifdef CLA_SAT_EN
    if (ctrl_v[STAGES-1].sat && ovf_d)
      s_d[STAGES-1] = a_v[STAGES-1][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
  end

  assign out_valid = ctrl_q[STAGES-1].valid;
  assign sum       = s_q[STAGES-1];
  assign cout      = ctrl_q[STAGES-1].carry;
  assign ovf       = ovf_q;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = reset && advance;

  // Payload only loads with a valid token, so outputs keep their last value across bubbles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= '0;
        a_q[k]    <= '0;
        be_q[k]   <= '0;
        s_q[k]    <= '0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctrl_q[k].valid <= ctrl_d[k].valid;
        if (ctrl_d[k].valid) begin
          ctrl_q[k] <= ctrl_d[k];
          a_q[k]    <= a_d[k];
          be_q[k]   <= be_d[k];
          s_q[k]    <= s_d[k];
        end
      end
      if (ctrl_d[STAGES-1].valid) ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and randomised checks of cla_pipe_addsub against an arithmetic reference model.
// Build with CLA_SAT_EN defined to also exercise saturation.
module tb_cla_pipe_addsub;
  localparam int N      = 16;
  localparam int GROUP  = 4;
  localparam int STAGES = 2;
  localparam longint HALF = longint'(1) << (N - 1);
  localparam longint FULL = longint'(1) << N;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         cin;
  logic         sat_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  int           total = 0;
  int           bad = 0;
  int           n_out = 0;
  logic [N+1:0] exp_q[$];
  logic [N+1:0] last_out;
  logic [N+1:0] held_out;
  bit           hold_pending;
  bit           seen_out;

  always #5 clk = ~clk;

  cla_pipe_addsub #(.N(N), .GROUP(GROUP), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
`ifdef CLA_SAT_EN
    .sat       (sat_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference: plain integer arithmetic; returns {cout, ovf, sum}.
  function automatic logic [N+1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic msub, input logic mcin, input logic msat);
    longint ua, ub, sa, sb, ures, sres;
    logic co, ov;
    logic [N-1:0] s;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = (ua >= HALF) ? ua - FULL : ua;
    sb = (ub >= HALF) ? ub - FULL : ub;
    if (msub) begin
      ures = ua - ub;
      co   = (ua >= ub);
      sres = sa - sb;
    end else begin
      ures = ua + ub + longint'(mcin);
      co   = (ures >= FULL);
      sres = sa + sb + longint'(mcin);
    end
    s  = ures[N-1:0];
    ov = (sres >= HALF) || (sres < -HALF);
    if (msat && ov) s = (sa < 0) ? N'(HALF) : N'(HALF - 1);
    return {co, ov, s};
  endfunction

  function automatic logic [N-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(N-1){1'b1}}};
      3:       return {1'b1, {(N-1){1'b0}}};
      default: return N'($urandom);
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 ns later, return at the next falling edge.
  task automatic step(input logic v, input logic [N-1:0] ta, input logic [N-1:0] ob,
                      input logic ts, input logic tc, input logic tsat, input logic ordy,
                      output bit acc);
    logic [N+1:0] got;
    logic [N+1:0] want;
    in_valid = v; a = ta; b = ob; sub = ts; cin = tc; sat_in = tsat; out_ready = ordy;
    #1;
    acc      = 1'b0;
    seen_out = 1'b0;
    got      = {cout, ovf, sum};
    if (!reset) begin
      chk("in_ready_rst", 32'(in_ready), 32'(0));
      hold_pending = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (hold_pending) begin
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_data", 32'(got), 32'(held_out));
      end
      hold_pending = out_valid && !out_ready;
      if (hold_pending) held_out = got;
      if (out_valid && exp_q.size() == 0) chk("extra_out", 32'(out_valid), 32'(0));
      if (out_valid && out_ready && exp_q.size() > 0) begin
        want     = exp_q.pop_front();
        seen_out = 1'b1;
        last_out = got;
        n_out++;
        chk("result", 32'(got), 32'(want));
        $display("xact %0d: sum=%h cout=%b ovf=%b model=%h", n_out, sum, cout, ovf, want);
      end
      if (v && in_ready) begin
        exp_q.push_back(model(ta, ob, ts, tc, tsat));
        acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic single(input string tag, input logic [N-1:0] ta, input logic [N-1:0] ob,
                        input logic ts, input logic tc, input logic tsat,
                        input logic [N+1:0] spec_val);
    bit acc;
    int lat;
    step(1'b1, ta, ob, ts, tc, tsat, 1'b1, acc);
    chk({tag, "_acc"}, 32'(acc), 32'(1));
    lat = 0;
    do begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
      lat++;
    end while (!seen_out && lat < 20);
    chk({tag, "_lat"}, 32'(lat), 32'(STAGES));
    chk({tag, "_val"}, 32'(last_out), 32'(spec_val));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           acc;
    bit           v;
    int           sent;
    int           cyc;
    int           n0;
    logic         tsat;
    logic [N-1:0] va [8];
    logic [N-1:0] vb [8];
    logic         vs [8];
    logic         vc [8];
    logic         pat [4];

    reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    sat_in = 1'b0; out_ready = 1'b0;
    hold_pending = 1'b0; seen_out = 1'b0; last_out = '0; held_out = '0;
    @(negedge clk);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    reset = 1'b1;

    single("add_basic", 16'h3333, 16'h1E1E, 1'b0, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5151});

    // Reset while a result is in flight: it must never appear.
    step(1'b1, 16'h3333, 16'h1E1E, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    reset = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    reset = 1'b1;
    exp_q.delete();
    hold_pending = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
      chk("flush_out_valid", 32'(out_valid), 32'(0));
    end

    single("carry_ripple", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b1, 1'b0, 16'h0000});
    single("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    single("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, {1'b0, 1'b0, 16'hFFFE});
    single("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, {1'b1, 1'b1, 16'h7FFF});
`ifdef CLA_SAT_EN
    single("sat_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 16'h7FFF});
    single("sat_neg", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, {1'b1, 1'b1, 16'h8000});
    single("nosat_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    single("nosat_neg", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, {1'b1, 1'b1, 16'h7FFF});
`endif

    // Backpressure: 8 back-to-back vectors against an out_ready pattern of 1,0,0,1.
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      va[i] = rand_op();
      vb[i] = rand_op();
      vs[i] = 1'($urandom_range(0, 1));
      vc[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; cyc = 0; n0 = n_out;
    while ((sent < 8 || exp_q.size() > 0) && cyc < 200) begin
      if (sent < 8) step(1'b1, va[sent], vb[sent], vs[sent], vc[sent], 1'b0, pat[cyc % 4], acc);
      else          step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, pat[cyc % 4], acc);
      if (acc) sent++;
      cyc++;
    end
    chk("bp_count", 32'(n_out - n0), 32'(8));
    chk("bp_drain", 32'(exp_q.size()), 32'(0));

    // Random regression with random input gaps and output stalls.
    sent = 0; cyc = 0; n0 = n_out;
    while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
      v = (sent < 1000) && ($urandom_range(0, 9) < 8);
`ifdef CLA_SAT_EN
      tsat = 1'($urandom_range(0, 1));
`else
      tsat = 1'b0;
`endif
      step(v, rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           tsat, ($urandom_range(0, 9) < 8), acc);
      if (acc) sent++;
      cyc++;
    end
    chk("reg_count", 32'(n_out - n0), 32'(1000));
    chk("reg_drain", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
